// File: rtl/requant_pkg.sv
// Shared requantization definitions: default widths, int8 activation limits
// and a reference RoundingDivideByPOT used by the SRDHM wrapper tests.
package requant_pkg;

  localparam int DEF_IN_W    = 32;
  localparam int DEF_OUT_W   = 8;
  localparam int DEF_SHIFT_W = 5;
  localparam int DEF_CNT_W   = 16;

  localparam logic signed [DEF_OUT_W-1:0] ACT_MIN = 8'sh80;
  localparam logic signed [DEF_OUT_W-1:0] ACT_MAX = 8'sh7f;

  // Arithmetic shift right by sh, rounding ties away from zero.
  function automatic logic signed [DEF_IN_W-1:0] rdbpot(
    input logic signed [DEF_IN_W-1:0]    x,
    input logic        [DEF_SHIFT_W-1:0] sh
  );
    logic [DEF_IN_W-1:0] mask;
    logic [DEF_IN_W-1:0] rem;
    logic [DEF_IN_W-1:0] thr;
    mask = ({{(DEF_IN_W-1){1'b0}}, 1'b1} << sh) - {{(DEF_IN_W-1){1'b0}}, 1'b1};
    rem  = x & mask;
    thr  = (mask >> 1) + {{(DEF_IN_W-1){1'b0}}, x[DEF_IN_W-1]};
    return (x >>> sh) + $signed({{(DEF_IN_W-1){1'b0}}, (rem > thr)});
  endfunction

endpackage

// File: rtl/rdbpot_round.sv
// Combinational RoundingDivideByPOT: x / 2^sh with ties rounded away from zero.
// A shift of zero passes x through unchanged.
module rdbpot_round #(
  parameter int IN_W    = 32,
  parameter int SHIFT_W = 5
) (
  input  logic [IN_W-1:0]    x,
  input  logic [SHIFT_W-1:0] sh,
  output logic [IN_W-1:0]    r
);

  logic [IN_W-1:0] mask;
  logic [IN_W-1:0] rem;
  logic [IN_W-1:0] thr;
  logic            round_up;

  // Negative values need a strictly larger remainder to round up, which turns
  // the floor of the arithmetic shift into round-half-away-from-zero.
  always_comb begin
    mask     = ({{(IN_W-1){1'b0}}, 1'b1} << sh) - {{(IN_W-1){1'b0}}, 1'b1};
    rem      = x & mask;
    thr      = (mask >> 1) + {{(IN_W-1){1'b0}}, x[IN_W-1]};
    round_up = (rem > thr);
    r        = $unsigned($signed(x) >>> sh) + {{(IN_W-1){1'b0}}, round_up};
  end

endmodule

// File: rtl/rdbpot_requant_pipe.sv
// Requantization back end: rounding divide, output offset, clamp to the
// activation range, int8 out. Two-stage valid/ready pipeline plus a
// saturating count of clamped beats.
module rdbpot_requant_pipe
  import requant_pkg::*;
#(
  parameter int IN_W    = DEF_IN_W,
  parameter int OUT_W   = DEF_OUT_W,
  parameter int SHIFT_W = DEF_SHIFT_W,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [IN_W-1:0]    in_x,
  input  logic [SHIFT_W-1:0] in_shift,
  input  logic [IN_W-1:0]    in_offset,
  input  logic [OUT_W-1:0]   in_act_min,
  input  logic [OUT_W-1:0]   in_act_max,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OUT_W-1:0]   out_data,
  input  logic               sat_clr,
  output logic [CNT_W-1:0]   sat_count
);

  logic                    s1_valid;
  logic                    s2_valid;
  logic                    s1_adv;
  logic                    s2_adv;
  logic [IN_W-1:0]         rnd_r;
  logic [IN_W-1:0]         s1_r;
  logic [IN_W-1:0]         s1_off;
  logic [OUT_W-1:0]        s1_min;
  logic [OUT_W-1:0]        s1_max;
  logic signed [IN_W:0]    sum;
  logic signed [IN_W:0]    min_ext;
  logic signed [IN_W:0]    max_ext;
  logic [OUT_W-1:0]        clamp_val;
  logic                    clamp_hit;

  // Output register drains on ready; stage 1 may refill whenever stage 2 moves.
  assign s2_adv    = !s2_valid || out_ready;
  assign s1_adv    = !s1_valid || s2_adv;
  assign in_ready  = s1_adv;
  assign out_valid = s2_valid;

  rdbpot_round #(
    .IN_W    (IN_W),
    .SHIFT_W (SHIFT_W)
  ) u_round (
    .x  (in_x),
    .sh (in_shift),
    .r  (rnd_r)
  );

  // Add offset one bit wider so it cannot wrap, then clamp against the beat's range.
  always_comb begin
    sum       = $signed({s1_r[IN_W-1], s1_r}) + $signed({s1_off[IN_W-1], s1_off});
    min_ext   = $signed({{(IN_W+1-OUT_W){s1_min[OUT_W-1]}}, s1_min});
    max_ext   = $signed({{(IN_W+1-OUT_W){s1_max[OUT_W-1]}}, s1_max});
    clamp_val = sum[OUT_W-1:0];
    clamp_hit = 1'b0;
    if (sum < min_ext) begin
      clamp_val = s1_min;
      clamp_hit = 1'b1;
    end else if (sum > max_ext) begin
      clamp_val = s1_max;
      clamp_hit = 1'b1;
    end
  end

  // Stage 1 captures the rounded value together with that beat's offset and range.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_r     <= '0;
      s1_off   <= '0;
      s1_min   <= '0;
      s1_max   <= '0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_r   <= rnd_r;
        s1_off <= in_offset;
        s1_min <= in_act_min;
        s1_max <= in_act_max;
      end
    end
  end

  // Stage 2 is the output register; it holds steady while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      out_data <= '0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        out_data <= clamp_val;
      end
    end
  end

  // Count clamped beats as they enter stage 2; clear wins and the count sticks at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_count <= '0;
    end else if (sat_clr) begin
      sat_count <= '0;
    end else if (s2_adv && s1_valid && clamp_hit && (sat_count != {CNT_W{1'b1}})) begin
      sat_count <= sat_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_rdbpot_requant_pipe.sv
// Scoreboard bench for the requantization pipe: the driver pushes the
// expected int8 result of each accepted beat, the monitor pops on each
// output transfer.
module tb_rdbpot_requant_pipe;

  typedef struct {
    int data;
    bit clamped;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_x;
  logic [4:0]  in_shift;
  logic [31:0] in_offset;
  logic [7:0]  in_act_min;
  logic [7:0]  in_act_max;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        sat_clr;
  logic [15:0] sat_count;

  exp_t q[$];
  int   total;
  int   bad;
  int   model_sat;
  int   rdy_mode;

  rdbpot_requant_pipe dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_x       (in_x),
    .in_shift   (in_shift),
    .in_offset  (in_offset),
    .in_act_min (in_act_min),
    .in_act_max (in_act_max),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .sat_clr    (sat_clr),
    .sat_count  (sat_count)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: divide by 2^sh on magnitudes, round half away from zero, add offset, clamp.
  function automatic exp_t model(input int x, input int sh, input int off,
                                 input int mn, input int mx);
    exp_t   e;
    longint ax;
    longint rr;
    longint p;
    longint s;
    if (sh == 0) begin
      rr = longint'(x);
    end else begin
      p  = longint'(1) << sh;
      ax = (x < 0) ? -longint'(x) : longint'(x);
      rr = (ax + p / 2) / p;
      if (x < 0) rr = -rr;
    end
    s = rr + longint'(off);
    e.clamped = 1'b0;
    if (s < longint'(mn)) begin
      e.data    = mn;
      e.clamped = 1'b1;
    end else if (s > longint'(mx)) begin
      e.data    = mx;
      e.clamped = 1'b1;
    end else begin
      e.data = int'(s);
    end
    return e;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, want %0d", name, actual, expected);
    end
  endtask

  task automatic timeoutFail(input string name);
    total++;
    bad++;
    $display("[TB] FAIL %s: got timeout, want completion", name);
  endtask

  // Offer one beat until accepted; the expected result is queued at acceptance.
  task automatic applyStimulus(input int x, input int sh, input int off,
                               input int mn, input int mx);
    bit acc;
    int waited;
    acc    = 1'b0;
    waited = 0;
    @(negedge clk);
    in_valid   = 1'b1;
    in_x       = x;
    in_shift   = sh[4:0];
    in_offset  = off;
    in_act_min = mn[7:0];
    in_act_max = mx[7:0];
    while (!acc) begin
      #4;
      if (rst_n && in_ready) begin
        acc = 1'b1;
        q.push_back(model(x, sh, off, mn, mx));
      end
      @(posedge clk);
      if (!acc) begin
        waited++;
        if (waited > 200) begin
          timeoutFail("accept_timeout");
          break;
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Stop offering beats and wait until every expected beat has come out.
  task automatic drain();
    bit done;
    done = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 400; i++) begin
      #4;
      if (q.size() == 0 && !out_valid) begin
        done = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!done) timeoutFail("drain_timeout");
  endtask

  // Monitor: drives out_ready per mode and scores every output transfer.
  initial begin
    exp_t e;
    out_ready = 1'b1;
    forever begin
      @(negedge clk);
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'b0;
        default: out_ready = ($urandom_range(3) != 0);
      endcase
      #4;
      if (rst_n && out_valid && out_ready) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_beat: got %0d, want no beat", $signed(out_data));
        end else begin
          e = q.pop_front();
          checkOutput("out_data", int'($signed(out_data)), e.data);
          if (e.clamped && model_sat < 65535) model_sat++;
        end
      end
    end
  end

  // Hard stop in case something wedges outside the bounded waits.
  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: got no finish, want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed cases, reset behaviour, randomized run, then counter limits.
  initial begin
    int k;
    bit last_rdy;
    int x;
    int sh;
    int off;
    int mn;
    int mx;
    int a;
    int b;
    int need;
    int bx[4];

    total     = 0;
    bad       = 0;
    model_sat = 0;
    rdy_mode  = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_x      = '0;
    in_shift  = '0;
    in_offset = '0;
    in_act_min = 8'h80;
    in_act_max = 8'h7f;
    sat_clr   = 1'b0;

    #2;
    checkOutput("reset_out_valid", int'(out_valid), 0);
    checkOutput("reset_out_data", int'(out_data), 0);
    checkOutput("reset_sat_count", int'(sat_count), 0);
    @(negedge clk);
    #1 rst_n = 1'b1;

    $display("[TB] rounding ties");
    applyStimulus(5, 1, 0, -128, 127);
    applyStimulus(-5, 1, 0, -128, 127);
    applyStimulus(4, 1, 0, -128, 127);
    drain();
    checkOutput("sat_after_ties", int'(sat_count), 0);

    $display("[TB] shifts and offsets");
    applyStimulus(1000, 3, -128, -128, 127);
    applyStimulus(-1, 31, 0, -128, 127);
    applyStimulus(7, 0, 10, -128, 127);
    drain();
    checkOutput("sat_after_offsets", int'(sat_count), 0);

    $display("[TB] clamping");
    applyStimulus(32'h7fffffff, 0, 0, -128, 127);
    drain();
    checkOutput("sat_after_pos_clamp", int'(sat_count), 1);
    applyStimulus(32'h80000000, 0, -5, -128, 127);
    drain();
    checkOutput("sat_after_neg_clamp", int'(sat_count), 2);
    applyStimulus(30, 0, 0, -20, 20);
    drain();
    checkOutput("sat_after_narrow_clamp", int'(sat_count), 3);

    $display("[TB] backpressure");
    rdy_mode = 1;
    bx[0] = 10; bx[1] = 20; bx[2] = 30; bx[3] = 40;
    k = 0;
    last_rdy = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_x = bx[k];
      in_shift = '0;
      in_offset = '0;
      in_act_min = 8'h80;
      in_act_max = 8'h7f;
      #4;
      last_rdy = in_ready;
      if (in_ready) begin
        q.push_back(model(bx[k], 0, 0, -128, 127));
        k++;
      end
      @(posedge clk);
    end
    checkOutput("accepts_under_stall", k, 2);
    checkOutput("in_ready_stalled", int'(last_rdy), 0);
    rdy_mode = 0;
    while (k < 4) begin
      applyStimulus(bx[k], 0, 0, -128, 127);
      k++;
    end
    drain();

    $display("[TB] async reset mid-stream");
    rdy_mode = 1;
    applyStimulus(50, 0, 0, -128, 127);
    applyStimulus(60, 0, 0, -128, 127);
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    checkOutput("pre_reset_out_valid", int'(out_valid), 1);
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset_out_valid", int'(out_valid), 0);
    checkOutput("async_reset_out_data", int'(out_data), 0);
    checkOutput("async_reset_sat", int'(sat_count), 0);
    q.delete();
    model_sat = 0;
    rdy_mode = 0;
    @(negedge clk);
    #1 rst_n = 1'b1;
    applyStimulus(-77, 0, 0, -128, 127);
    @(negedge clk);
    in_valid = 1'b0;
    #4;
    checkOutput("latency_cycle1_valid", int'(out_valid), 0);
    @(negedge clk);
    #4;
    checkOutput("latency_cycle2_valid", int'(out_valid), 1);
    checkOutput("latency_cycle2_data", int'($signed(out_data)), -77);
    drain();

    $display("[TB] randomized run");
    rdy_mode = 2;
    for (int n = 0; n < 10000; n++) begin
      case ($urandom_range(3))
        0:       x = int'($urandom_range(0, 2000)) - 1000;
        1:       x = int'($urandom_range(0, 65535)) - 32768;
        default: x = int'($urandom);
      endcase
      sh  = int'($urandom_range(31));
      off = ($urandom_range(1) == 1) ? int'($urandom_range(0, 300)) - 150 : int'($urandom);
      if ($urandom_range(1) == 1) begin
        mn = -128;
        mx = 127;
      end else begin
        a = int'($urandom_range(0, 255)) - 128;
        b = int'($urandom_range(0, 255)) - 128;
        mn = (a < b) ? a : b;
        mx = (a < b) ? b : a;
      end
      if ($urandom_range(7) == 0) idle();
      applyStimulus(x, sh, off, mn, mx);
    end
    drain();
    checkOutput("sat_after_random", int'(sat_count), model_sat);

    $display("[TB] counter saturation");
    rdy_mode = 0;
    need = 65535 - model_sat;
    for (int n = 0; n < need; n++) begin
      applyStimulus(32'h7fffffff, 0, 0, -128, 127);
    end
    drain();
    checkOutput("sat_full", int'(sat_count), 65535);
    applyStimulus(32'h80000000, 0, 0, -128, 127);
    drain();
    checkOutput("sat_hold", int'(sat_count), 65535);

    applyStimulus(32'h7fffffff, 0, 0, -128, 127);
    @(negedge clk);
    in_valid = 1'b0;
    sat_clr = 1'b1;
    @(negedge clk);
    sat_clr = 1'b0;
    drain();
    checkOutput("sat_clr_with_clamp", int'(sat_count), 0);
    model_sat = 0;
    applyStimulus(200, 0, 0, -128, 127);
    drain();
    checkOutput("sat_after_clear", int'(sat_count), model_sat);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
